// File: rtl/cordic_pkg.sv
// Shared constants for the vector_angle CORDIC block: data widths, arctangent table,
// gain-compensation constant and FSM state type.
package cordic_pkg;

  localparam int unsigned FloatBits     = 32;
  localparam int unsigned IntBits       = 32;
  localparam int unsigned Guard         = 2;
  localparam int unsigned MaxIterations = 20;

  // 1/K for the CORDIC gain, Q16 (0.607253)
  localparam int unsigned KINV = 39797;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StIter,
    StFinish,
    StDone
  } state_e;

  // atan(2^-i) in degrees, scaled by 2^16 and rounded to nearest.
  function automatic logic [31:0] atan_q16(input logic [4:0] i);
    logic [31:0] v;
    case (i)
      5'd0:    v = 32'd2949120;
      5'd1:    v = 32'd1740967;
      5'd2:    v = 32'd919879;
      5'd3:    v = 32'd466945;
      5'd4:    v = 32'd234379;
      5'd5:    v = 32'd117304;
      5'd6:    v = 32'd58666;
      5'd7:    v = 32'd29335;
      5'd8:    v = 32'd14668;
      5'd9:    v = 32'd7334;
      5'd10:   v = 32'd3667;
      5'd11:   v = 32'd1833;
      5'd12:   v = 32'd917;
      5'd13:   v = 32'd458;
      5'd14:   v = 32'd229;
      5'd15:   v = 32'd115;
      5'd16:   v = 32'd57;
      5'd17:   v = 32'd29;
      5'd18:   v = 32'd14;
      5'd19:   v = 32'd7;
      default: v = 32'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup, indexed by the CORDIC iteration counter and rescaled
// to the angle accumulator's fractional width.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int unsigned ANG_FRAC = 16,
  parameter int unsigned AngW     = ANG_FRAC + 11
) (
  input  logic        [4:0]      idx,
  output logic signed [AngW-1:0] atan
);

  logic [31:0] base;

  assign base = atan_q16(idx);

  if (ANG_FRAC >= 16) begin : g_scale_up
    assign atan = AngW'(base) << (ANG_FRAC - 16);
  end else begin : g_scale_down
    assign atan = AngW'(base >> (16 - ANG_FRAC));
  end

endmodule

// File: rtl/vector_angle.sv
// Iterative CORDIC vectoring: returns atan2(y,x) as integer degrees 0..359 and the
// gain-compensated magnitude, one micro-rotation per clock on a single shared datapath.
module vector_angle
  import cordic_pkg::*;
#(
  parameter int unsigned ITERATIONS = 16,
  parameter int unsigned FRAC_BITS  = 16,
  parameter int unsigned ANG_FRAC   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [FloatBits-1:0] x,
  input  logic signed [FloatBits-1:0] y,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [IntBits-1:0]   angle,
  output logic signed [FloatBits-1:0] mag,
  output logic                        zero
);

  localparam int unsigned W  = FloatBits + Guard;
  localparam int unsigned ZW = ANG_FRAC + 11;
  localparam int unsigned PW = W + 18;

  localparam logic signed [ZW-1:0]        Z180   = ZW'(180) << ANG_FRAC;
  localparam logic signed [ZW-1:0]        Half   = ZW'(1) << (ANG_FRAC - 1);
  localparam logic signed [ZW-1:0]        Deg360 = ZW'(360);
  localparam logic signed [17:0]          KinvS  = 18'(KINV);
  localparam logic signed [FloatBits-1:0] MaxPos = {1'b0, {(FloatBits - 1){1'b1}}};

  if (ITERATIONS < 1 || ITERATIONS > MaxIterations) begin : g_bad_iterations
    $error("vector_angle: ITERATIONS must be in 1..20");
  end
  if (FRAC_BITS < 1 || FRAC_BITS >= FloatBits) begin : g_bad_frac_bits
    $error("vector_angle: FRAC_BITS must be in 1..FloatBits-1");
  end

  state_e                      state_q;
  logic                        in_ready_q;
  logic                        out_valid_q;
  logic signed [IntBits-1:0]   angle_q;
  logic signed [FloatBits-1:0] mag_q;
  logic                        zero_q;
  logic                        zero_in_q;
  logic signed [W-1:0]         x_q;
  logic signed [W-1:0]         y_q;
  logic signed [ZW-1:0]        z_q;
  logic        [4:0]           iter_q;

  logic signed [ZW-1:0]        atan;
  logic signed [W-1:0]         xs;
  logic signed [W-1:0]         ys;
  logic signed [W-1:0]         x_nx;
  logic signed [W-1:0]         y_nx;
  logic signed [ZW-1:0]        z_nx;
  logic signed [ZW-1:0]        z_abs;
  logic signed [ZW-1:0]        z_rnd;
  logic signed [ZW-1:0]        deg;
  logic signed [PW-1:0]        prod;
  logic signed [PW-1:0]        prod_sh;
  logic signed [FloatBits-1:0] mag_sat;

  cordic_atan_rom #(
    .ANG_FRAC(ANG_FRAC),
    .AngW    (ZW)
  ) u_atan_rom (
    .idx (iter_q),
    .atan(atan)
  );

  always_comb begin
    xs = x_q >>> iter_q;
    ys = y_q >>> iter_q;
    // Both updates use the pre-rotation x and y.
    if (!y_q[W-1]) begin
      x_nx = x_q + ys;
      y_nx = y_q - xs;
      z_nx = z_q + atan;
    end else begin
      x_nx = x_q - ys;
      y_nx = y_q + xs;
      z_nx = z_q - atan;
    end

    // Round to nearest degree, ties away from zero, then fold into 0..359.
    z_abs = z_q[ZW-1] ? -z_q : z_q;
    z_rnd = (z_abs + Half) >> ANG_FRAC;
    deg   = z_q[ZW-1] ? -z_rnd : z_rnd;
    if (deg < 0) begin
      deg = deg + Deg360;
    end else if (deg == Deg360) begin
      deg = '0;
    end

    prod    = PW'(x_q) * PW'(KinvS);
    prod_sh = prod >>> 16;
    if (prod_sh > PW'(MaxPos)) begin
      mag_sat = MaxPos;
    end else if (prod_sh < 0) begin
      mag_sat = '0;
    end else begin
      mag_sat = prod_sh[FloatBits-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      angle_q     <= '0;
      mag_q       <= '0;
      zero_q      <= 1'b0;
      zero_in_q   <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      iter_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            x_q        <= {{Guard{x[FloatBits-1]}}, x};
            y_q        <= {{Guard{y[FloatBits-1]}}, y};
            zero_in_q  <= (x == '0) && (y == '0);
            in_ready_q <= 1'b0;
            state_q    <= StPre;
          end
        end
        StPre: begin
          // Fold the left half-plane into the right so the rotations converge.
          if (x_q[W-1]) begin
            x_q <= -x_q;
            y_q <= -y_q;
            z_q <= Z180;
          end else begin
            z_q <= '0;
          end
          iter_q  <= '0;
          state_q <= StIter;
        end
        StIter: begin
          x_q <= x_nx;
          y_q <= y_nx;
          z_q <= z_nx;
          if (iter_q == 5'(ITERATIONS - 1)) begin
            state_q <= StFinish;
          end else begin
            iter_q <= iter_q + 5'd1;
          end
        end
        StFinish: begin
          if (zero_in_q) begin
            angle_q <= '0;
            mag_q   <= '0;
          end else begin
            angle_q <= IntBits'(deg);
            mag_q   <= mag_sat;
          end
          zero_q      <= zero_in_q;
          out_valid_q <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign angle     = angle_q;
  assign mag       = mag_q;
  assign zero      = zero_q;

endmodule
